// File: rtl/regfile_writeback_pkg.sv
// ----------------------------------------------------------------------------
// regfile_writeback_pkg
// Shared definitions for the write-back stage: register file geometry and the
// identity of the two result sources that compete for the single write port.
// ----------------------------------------------------------------------------
package regfile_writeback_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;

    // Result sources. SRC_ALU is encoded as 0 so that a freshly reset
    // "last granted = LSU" state hands the first conflict to the ALU.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    // Round-robin successor: the source that wins a conflict after `last`.
    function automatic src_e rr_next(input src_e last);
        return (last == SRC_ALU) ? SRC_LSU : SRC_ALU;
    endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// ----------------------------------------------------------------------------
// regfile_writeback_if
// Bundles every non-clock signal of the write-back stage.
//   issue   : iss_valid, iss_rd            -> iss_ready
//   ALU     : alu_valid, alu_rd, alu_data  -> alu_ready
//   LSU     : lsu_valid, lsu_rd, lsu_data  -> lsu_ready
//   RF port : rf_wen, rf_rd_addr, rf_rd_data (from the write-back stage)
//   hazard  : rs1_addr, rs2_addr           -> rs1_busy, rs2_busy
// Modports:
//   slave  - the write-back stage itself
//   master - the surrounding pipeline (decoder, ALU, LSU, register file)
// ----------------------------------------------------------------------------
interface regfile_writeback_if #(
    parameter int WIDTH = 32
);

    logic                                      iss_valid;
    logic [regfile_writeback_pkg::REG_AW-1:0] iss_rd;
    logic                                      iss_ready;

    logic                                      alu_valid;
    logic                                      alu_ready;
    logic [regfile_writeback_pkg::REG_AW-1:0] alu_rd;
    logic [WIDTH-1:0]                          alu_data;

    logic                                      lsu_valid;
    logic                                      lsu_ready;
    logic [regfile_writeback_pkg::REG_AW-1:0] lsu_rd;
    logic [WIDTH-1:0]                          lsu_data;

    logic                                      rf_wen;
    logic [regfile_writeback_pkg::REG_AW-1:0] rf_rd_addr;
    logic [WIDTH-1:0]                          rf_rd_data;

    logic [regfile_writeback_pkg::REG_AW-1:0] rs1_addr;
    logic [regfile_writeback_pkg::REG_AW-1:0] rs2_addr;
    logic                                      rs1_busy;
    logic                                      rs2_busy;

    modport slave (
        input  iss_valid, iss_rd,
        output iss_ready,
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  lsu_valid, lsu_rd, lsu_data,
        output lsu_ready,
        output rf_wen, rf_rd_addr, rf_rd_data,
        input  rs1_addr, rs2_addr,
        output rs1_busy, rs2_busy
    );

    modport master (
        output iss_valid, iss_rd,
        input  iss_ready,
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready,
        input  rf_wen, rf_rd_addr, rf_rd_data,
        output rs1_addr, rs2_addr,
        input  rs1_busy, rs2_busy
    );

endinterface

// File: rtl/regfile_writeback_wb_arbiter.sv
// ----------------------------------------------------------------------------
// wb_arbiter
// Two-way round-robin arbiter between the ALU and LSU result streams.
// Ports:
//   clk, rst             - clock, asynchronous active-low reset
//   alu_valid, lsu_valid - request from each source
//   alu_gnt, lsu_gnt     - per-source readiness; a transfer happens where the
//                          source's valid and its grant are both high
// The grants depend only on the *other* source's valid and on rr_last, never
// on the source's own valid, so a source may look at its ready before it
// raises valid without creating a combinational loop.
// ----------------------------------------------------------------------------
module wb_arbiter
    import regfile_writeback_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic alu_valid,
    input  logic lsu_valid,
    output logic alu_gnt,
    output logic lsu_gnt
);

    src_e rr_last;

    // A source is only held off when the other one is competing and the
    // held-off source was the one granted last time.
    assign alu_gnt = !(lsu_valid && (rr_last == SRC_ALU));
    assign lsu_gnt = !(alu_valid && (rr_last == SRC_LSU));

    // History only moves on a real conflict; an uncontested grant leaves the
    // priority where it was.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last <= SRC_LSU;
        end else if (alu_valid && lsu_valid) begin
            rr_last <= rr_next(rr_last);
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// ----------------------------------------------------------------------------
// regfile_writeback
// Write-back stage: arbitrates ALU and LSU results onto one register file
// write port and keeps a busy scoreboard for hazard detection.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous active-low reset
//   bus  - regfile_writeback_if.slave: issue handshake, ALU/LSU result
//          handshakes, registered register-file write port, rs1/rs2 hazard
//          query
// Timing:
//   issue accepted at edge N       -> busy[rd] = 1 after edge N
//   result transfer at edge N      -> rf_wen/addr/data valid after edge N
//   rf_wen cycle ends at edge N+1  -> busy[rd] = 0 after edge N+1
// ----------------------------------------------------------------------------
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_writeback_if.slave   bus
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    logic                alu_gnt;
    logic                lsu_gnt;
    logic                alu_xfer;
    logic                lsu_xfer;
    logic                iss_fire;

    logic [REG_AW-1:0]   win_rd;
    logic [WIDTH-1:0]    win_data;

    logic                wen_q;
    logic [REG_AW-1:0]   addr_q;
    logic [WIDTH-1:0]    data_q;

    wb_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (bus.alu_valid),
        .lsu_valid (bus.lsu_valid),
        .alu_gnt   (alu_gnt),
        .lsu_gnt   (lsu_gnt)
    );

    assign bus.alu_ready = alu_gnt;
    assign bus.lsu_ready = lsu_gnt;

    // The arbiter guarantees at most one of these is high in a cycle.
    assign alu_xfer = bus.alu_valid && alu_gnt;
    assign lsu_xfer = bus.lsu_valid && lsu_gnt;

    assign win_rd   = alu_xfer ? bus.alu_rd   : bus.lsu_rd;
    assign win_data = alu_xfer ? bus.alu_data : bus.lsu_data;

    // WAW stall: a register with a result still outstanding cannot be
    // re-issued. x0 is never tracked, so it is always ready.
    assign bus.iss_ready = (bus.iss_rd == '0) || !busy[bus.iss_rd];
    assign iss_fire      = bus.iss_valid && bus.iss_ready;

    assign bus.rs1_busy = busy[bus.rs1_addr];
    assign bus.rs2_busy = busy[bus.rs2_addr];

    // Clear happens at the edge that ends the rf_wen cycle, so a reader
    // sees busy until the register file actually holds the value. A new
    // issue to the same register in that cycle is applied after the clear
    // and therefore wins.
    always_comb begin
        busy_next = busy;
        if (wen_q) begin
            busy_next[addr_q] = 1'b0;
        end
        if (iss_fire) begin
            busy_next[bus.iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Registered write port: one cycle after the transfer, for one cycle.
    // A result for x0 is consumed but never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wen_q <= (alu_xfer || lsu_xfer) && (win_rd != '0);
            if (alu_xfer || lsu_xfer) begin
                addr_q <= win_rd;
                data_q <= win_data;
            end
        end
    end

    assign bus.rf_wen     = wen_q;
    assign bus.rf_rd_addr = addr_q;
    assign bus.rf_rd_data = data_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// ----------------------------------------------------------------------------
// tb_regfile_writeback
// Directed bench for regfile_writeback. Inputs are driven 1 time unit after
// the rising edge; outputs are sampled 1-2 time units after the edge.
// ----------------------------------------------------------------------------
module tb_regfile_writeback;

    logic clk;
    logic rst;

    int n_cmp;
    int n_err;

    regfile_writeback_if #(.WIDTH(32)) bus ();

    regfile_writeback #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.lsu_valid = 1'b0;
        bus.lsu_rd    = '0;
        bus.lsu_data  = '0;
        bus.rs1_addr  = '0;
        bus.rs2_addr  = '0;
    endtask

    // Conflict table: both sources valid for four cycles, then ALU alone.
    logic [4:0]  a_rd   [5] = '{5'd1, 5'd3, 5'd3, 5'd6, 5'd6};
    logic [4:0]  l_rd   [5] = '{5'd2, 5'd2, 5'd4, 5'd4, 5'd0};
    logic        l_v    [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        exp_ar [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        exp_lr [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [4:0]  wr_rd  [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6};
    logic [31:0] wr_dat [5] = '{32'hA000_0001, 32'hB000_0002, 32'hA000_0003,
                                32'hB000_0004, 32'hA000_0006};

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        idle();

        // Reset state
        repeat (3) tick();
        bus.rs1_addr = 5'd5;
        settle();
        check("rst_wen",   bus.rf_wen,     1'b0);
        check("rst_addr",  bus.rf_rd_addr, 5'd0);
        check("rst_data",  bus.rf_rd_data, 32'd0);
        check("rst_busy5", bus.rs1_busy,   1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Issue rd=5, ALU result to rd=5
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd5;
        settle();
        check("iss5_ready", bus.iss_ready, 1'b1);
        tick();
        bus.iss_valid = 1'b0;
        bus.rs1_addr  = 5'd5;
        settle();
        check("busy5_set", bus.rs1_busy, 1'b1);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'hDEAD_BEEF;
        settle();
        check("alu_ready_solo", bus.alu_ready, 1'b1);
        check("busy5_pre_xfer", bus.rs1_busy, 1'b1);
        tick();
        bus.alu_valid = 1'b0;
        settle();
        check("w5_wen",  bus.rf_wen,     1'b1);
        check("w5_addr", bus.rf_rd_addr, 5'd5);
        check("w5_data", bus.rf_rd_data, 32'hDEAD_BEEF);
        check("busy5_in_wen", bus.rs1_busy, 1'b1);
        tick();
        check("w5_wen_off", bus.rf_wen,   1'b0);
        check("busy5_clr",  bus.rs1_busy, 1'b0);

        // rd=0 issue is always ready and never marks busy
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd0;
        settle();
        check("iss0_ready", bus.iss_ready, 1'b1);
        tick();
        bus.iss_valid = 1'b0;
        bus.rs1_addr  = 5'd0;
        settle();
        check("busy0_zero", bus.rs1_busy, 1'b0);

        // Round-robin under sustained conflict
        for (int i = 0; i < 5; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = a_rd[i];
            bus.alu_data  = 32'hA000_0000 | 32'(a_rd[i]);
            bus.lsu_valid = l_v[i];
            bus.lsu_rd    = l_rd[i];
            bus.lsu_data  = 32'hB000_0000 | 32'(l_rd[i]);
            settle();
            check($sformatf("rr%0d_alu_ready", i), bus.alu_ready, exp_ar[i]);
            check($sformatf("rr%0d_lsu_ready", i), bus.lsu_ready, exp_lr[i]);
            tick();
            check($sformatf("rr%0d_wen", i),  bus.rf_wen,     1'b1);
            check($sformatf("rr%0d_addr", i), bus.rf_rd_addr, wr_rd[i]);
            check($sformatf("rr%0d_data", i), bus.rf_rd_data, wr_dat[i]);
        end
        idle();
        bus.rs2_addr = 5'd3;
        tick();
        check("rr_wen_off",     bus.rf_wen,   1'b0);
        check("unbusy_write_3", bus.rs2_busy, 1'b0);

        // WAW stall on rd=7
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd7;
        settle();
        check("iss7_first", bus.iss_ready, 1'b1);
        tick();
        check("iss7_stall_a", bus.iss_ready, 1'b0);
        tick();
        check("iss7_stall_b", bus.iss_ready, 1'b0);
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd7;
        bus.lsu_data  = 32'hC0DE_0007;
        settle();
        check("lsu7_ready",   bus.lsu_ready, 1'b1);
        check("iss7_stall_c", bus.iss_ready, 1'b0);
        tick();
        bus.lsu_valid = 1'b0;
        settle();
        check("w7_wen",       bus.rf_wen,     1'b1);
        check("w7_addr",      bus.rf_rd_addr, 5'd7);
        check("w7_data",      bus.rf_rd_data, 32'hC0DE_0007);
        check("iss7_stall_d", bus.iss_ready,  1'b0);
        tick();
        check("iss7_go", bus.iss_ready, 1'b1);
        tick();
        bus.iss_valid = 1'b0;
        bus.rs1_addr  = 5'd7;
        settle();
        check("busy7_reissued", bus.rs1_busy, 1'b1);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd7;
        bus.alu_data  = 32'h7777_7777;
        tick();
        bus.alu_valid = 1'b0;
        tick();
        check("busy7_retired", bus.rs1_busy, 1'b0);

        // LSU result to x0 with rd=9 outstanding
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd9;
        tick();
        bus.iss_valid = 1'b0;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd0;
        bus.lsu_data  = 32'h0000_1234;
        settle();
        check("lsu0_ready", bus.lsu_ready, 1'b1);
        tick();
        bus.lsu_valid = 1'b0;
        bus.rs1_addr  = 5'd9;
        bus.rs2_addr  = 5'd0;
        settle();
        check("x0_wen",      bus.rf_wen,   1'b0);
        check("x0_busy9",    bus.rs1_busy, 1'b1);
        check("x0_busy0",    bus.rs2_busy, 1'b0);
        bus.rs2_addr = 5'd7;
        settle();
        check("x0_busy7",    bus.rs2_busy, 1'b0);

        // Move priority to LSU with an ALU win, so reset must restore it
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd0;
        settle();
        check("pre_alu_win", bus.alu_ready, 1'b1);
        tick();
        bus.alu_valid = 1'b0;
        settle();
        check("pre_lsu_drain", bus.lsu_ready, 1'b1);
        tick();
        bus.lsu_valid = 1'b0;

        // Reset during an in-flight write to rd=3
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd3;
        tick();
        bus.iss_valid = 1'b0;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_data  = 32'h3333_3333;
        tick();
        bus.alu_valid = 1'b0;
        settle();
        check("w3_wen_before_rst", bus.rf_wen, 1'b1);
        rst = 1'b0;
        bus.rs1_addr = 5'd3;
        bus.rs2_addr = 5'd9;
        settle();
        check("arst_wen",   bus.rf_wen,     1'b0);
        check("arst_addr",  bus.rf_rd_addr, 5'd0);
        check("arst_data",  bus.rf_rd_data, 32'd0);
        check("arst_busy3", bus.rs1_busy,   1'b0);
        check("arst_busy9", bus.rs2_busy,   1'b0);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd1;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd2;
        settle();
        check("post_rst_alu_ready", bus.alu_ready, 1'b1);
        check("post_rst_lsu_ready", bus.lsu_ready, 1'b0);
        tick();
        bus.alu_valid = 1'b0;
        tick();
        bus.lsu_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of every result and of the register file write port.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-004 SHALL have port iss_valid  input  1: the decoder is issuing an instruction that writes a register.
REQ-005 SHALL have port iss_rd  input  5: destination register of the issued instruction.
REQ-006 SHALL have port iss_ready  output  1: the issue is accepted this cycle.
REQ-007 SHALL have ports alu_valid/alu_ready  input/output  1 each: ALU result handshake.
REQ-008 SHALL have ports alu_rd  input  5 and alu_data  input  WIDTH: ALU result destination and value.
REQ-009 SHALL have ports lsu_valid/lsu_ready  input/output  1 each, lsu_rd  input  5 and lsu_data  input  WIDTH: LSU result handshake and payload.
REQ-010 SHALL have ports rf_wen  output  1, rf_rd_addr  output  5 and rf_rd_data  output  WIDTH: register file write port.
REQ-011 SHALL have ports rs1_addr/rs2_addr  input  5 and rs1_busy/rs2_busy  output  1: hazard query.

Function
REQ-012 An issue SHALL be accepted when iss_valid && iss_ready; iss_ready = !busy[iss_rd] (WAW stall), and iss_rd==0 SHALL always be ready.
REQ-013 An accepted issue with iss_rd!=0 SHALL set busy[iss_rd] at the next edge; busy[0] SHALL be constant 0.
REQ-014 A source transfer SHALL occur when its valid && ready; payload SHALL be held stable by the source while valid && !ready.
REQ-015 Arbitration SHALL be 2-way round-robin: if only one source is valid, it is granted; if both are valid, the source not granted last SHALL win; after reset ALU has priority.
REQ-016 alu_ready = !(lsu_valid && rr_last==ALU); lsu_ready = !(alu_valid && rr_last==LSU); readies SHALL depend only on the valids and rr_last.
REQ-017 rr_last SHALL update only on a cycle in which both sources are valid.
REQ-018 The granted transfer SHALL be registered: rf_wen, rf_rd_addr, rf_rd_data SHALL be driven exactly one cycle after the transfer, for one cycle.
REQ-019 A transfer with rd==0 SHALL be consumed but SHALL produce rf_wen=0.
REQ-020 busy[rd] SHALL clear at the edge ending the rf_wen cycle, so that rsN_busy remains 1 until the register file holds the new value.
REQ-021 rs1_busy = busy[rs1_addr] and rs2_busy = busy[rs2_addr], combinational, zero latency.
REQ-022 A transfer whose rd is not busy SHALL still be written; busy stays 0 (no error flag).
REQ-023 Sustained throughput SHALL be one write per cycle with back-to-back transfers.

Reset
REQ-024 While rst=0: busy vector 0, rf_wen 0, rf_rd_addr 0, rf_rd_data 0, rr_last=LSU (so ALU wins first conflict).
REQ-025 Reset SHALL take effect asynchronously; deassertion is synchronized externally; an in-flight registered write SHALL be discarded.

Structure
REQ-026 A shared package SHALL hold NUM_REGS=32, REG_AW=5 and the source enum {SRC_ALU, SRC_LSU}.
REQ-027 Arbitration SHALL live in one sub-module wb_arbiter (two valid inputs, two grant outputs, rr_last state); scoreboard and output register stay in regfile_writeback.

Verification
REQ-028 Issue rd=5, then ALU transfer rd=5 data=0xDEADBEEF -> rs1_busy(5)=1 until rf_wen cycle inclusive, rf_wen=1 addr=5 data=0xDEADBEEF one cycle after transfer, busy(5)=0 afterwards.
REQ-029 ALU and LSU both valid for 4 cycles (rd 1..4) -> grants ALU, LSU, ALU, LSU; four consecutive rf_wen cycles.
REQ-030 Issue rd=7 while busy[7]=1 -> iss_ready=0 until the rd=7 write retires, then accepted next cycle.
REQ-031 LSU transfer rd=0 data=0x1234 -> lsu_ready=1, rf_wen stays 0, busy vector unchanged.
REQ-032 Assert rst low the cycle after an ALU transfer to rd=3 -> rf_wen=0 immediately, busy(3)=0, first conflict after reset grants ALU.
